// File: rtl/draw_decimal.sv
// Decimal HUD renderer: binary value -> BCD via multi-cycle double-dabble,
// committed at frame boundaries, drawn as scaled 4x5 glyphs with a registered pixel.
module draw_decimal #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCALE      = 4,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [IN_WIDTH-1:0] number,
  input  logic [10:0]         curr_x,
  input  logic [9:0]          curr_y,
  input  logic [10:0]         pos_x,
  input  logic [9:0]          pos_y,
  output logic                pixel_on,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned CW      = 5 * SCALE;
  localparam int unsigned CH      = 5 * SCALE;
  localparam int unsigned FIELD_W = NUM_DIGITS * CW;
  localparam int unsigned CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int unsigned GW      = 16;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  function automatic logic [63:0] pow10_m1(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(NUM_DIGITS);

  function automatic logic [19:0] font(input logic [3:0] d);
    case (d)
      4'd0:    return 20'h69996;
      4'd1:    return 20'h22222;
      4'd2:    return 20'h6124F;
      4'd3:    return 20'h61216;
      4'd4:    return 20'h99F11;
      4'd5:    return 20'hF8E1E;
      4'd6:    return 20'h68E96;
      4'd7:    return 20'hF1244;
      4'd8:    return 20'h69696;
      4'd9:    return 20'h69716;
      default: return 20'h00000;
    endcase
  endfunction

  logic [0:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] last_num_q;
  logic [IN_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                sat_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BCD_W-1:0]    res_bcd_q;
  logic                res_sat_q;
  logic                res_valid_q;
  logic [BCD_W-1:0]    disp_bcd_q;

  logic                start_c;
  logic                last_step_c;
  logic                sat_c;
  logic                commit_c;
  logic [BCD_W-1:0]    bcd_adj_c;
  logic [BCD_W-1:0]    bcd_next_c;
  logic [IN_WIDTH-1:0] bin_next_c;

  assign start_c     = (state_q == S_IDLE) && (number != last_num_q);
  assign last_step_c = (state_q == S_CONV) && (cnt_q == CNT_W'(IN_WIDTH - 1));
  assign sat_c       = 64'(number) > MAX_VAL;
  assign commit_c    = frame_start && res_valid_q;

  // Double-dabble step: add-3 correction on every nibble, then shift in the next binary bit
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_next_c = {bcd_adj_c[BCD_W-2:0], bin_q[IN_WIDTH-1]};
  assign bin_next_c = {bin_q[IN_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = S_CONV;
      S_CONV:  if (last_step_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion datapath and result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_num_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      res_bcd_q  <= '0;
      res_sat_q  <= 1'b0;
      busy       <= 1'b0;
    end else if (start_c) begin
      last_num_q <= number;
      bin_q      <= sat_c ? IN_WIDTH'(MAX_VAL) : number;
      sat_q      <= sat_c;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy       <= 1'b1;
    end else if (state_q == S_CONV) begin
      bin_q <= bin_next_c;
      bcd_q <= bcd_next_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step_c) begin
        res_bcd_q <= bcd_next_c;
        res_sat_q <= sat_q;
        busy      <= 1'b0;
      end
    end
  end

  // A result landing in the same cycle as frame_start waits for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      disp_bcd_q  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (last_step_c)   res_valid_q <= 1'b1;
      else if (commit_c) res_valid_q <= 1'b0;
      if (commit_c) begin
        disp_bcd_q <= res_bcd_q;
        overflow   <= res_sat_q;
      end
    end
  end

  logic [GW-1:0] cx_c, cy_c, px_c, py_c, rx_c, ry_c, idx_c, dx_c, dy_c;
  logic          in_field_c;
  logic [3:0]    digit_c;
  logic          blank_c;
  logic          zero_run_c;
  logic [19:0]   glyph_c;
  logic [19:0]   glyph_sh_c;
  logic [4:0]    gidx_c;
  logic          hit_c;

  // Widened geometry so pos + field width never wraps
  assign cx_c       = GW'(curr_x);
  assign cy_c       = GW'(curr_y);
  assign px_c       = GW'(pos_x);
  assign py_c       = GW'(pos_y);
  assign in_field_c = (cx_c >= px_c) && (cx_c < px_c + GW'(FIELD_W)) &&
                      (cy_c >= py_c) && (cy_c < py_c + GW'(CH));
  assign rx_c       = cx_c - px_c;
  assign ry_c       = cy_c - py_c;
  assign idx_c      = rx_c / GW'(CW);
  assign dx_c       = (rx_c % GW'(CW)) / GW'(SCALE);
  assign dy_c       = ry_c / GW'(SCALE);

  // Digit lookup and leading-zero run for the current cell
  always_comb begin
    digit_c    = 4'd0;
    blank_c    = 1'b0;
    zero_run_c = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_run_c = zero_run_c && (disp_bcd_q[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
      if (idx_c == GW'(i)) begin
        digit_c = disp_bcd_q[(NUM_DIGITS-1-i)*4 +: 4];
        blank_c = (BLANK_LZ != 0) && zero_run_c && (i < NUM_DIGITS - 1);
      end
    end
  end

  assign glyph_c    = font(digit_c);
  assign gidx_c     = 5'(dy_c * GW'(4) + dx_c);
  assign glyph_sh_c = glyph_c << gidx_c;
  assign hit_c      = in_field_c && (dx_c < GW'(4)) && !blank_c && glyph_sh_c[19];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_on <= 1'b0;
    else        pixel_on <= hit_c;
  end

endmodule
